sccb_cmd_arbiter: RTL

- Shares one SCCB write engine between NUM_REQ command sources, for example the boot-time register table and a runtime exposure/gain tuner.
- Each requester presents a 16-bit command: {register address[15:8], data[7:0]}.
- The arbiter selects one requester round-robin, drives the engine's send/address/value inputs, and waits for the engine's taken pulse.
- It then enforces an inter-command gap and returns a one-cycle ack (or a timeout error) to the granted requester.
- Sits between the sensor configuration sources and the single SCCB interface instance.

---
 rtl/sccb_cmd_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sccb_cmd_arbiter.sv
// Round-robin arbiter sharing one SCCB write engine among NUM_REQ command sources.
// Optional feature macro: SCCB_ARB_PRIO0_EN (requester 0 gets strict priority).
module sccb_cmd_arbiter #(
  parameter int          NUM_REQ        = 2,
  parameter logic [15:0] GAP_CYCLES     = 16'd5000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  cmd,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     err,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   sccb_send,
  output logic [7:0]             sccb_rega,
  output logic [7:0]             sccb_value,
  input  logic                   sccb_taken
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef SCCB_ARB_PRIO0_EN
  localparam logic PRIO0 = 1'b1;
`else
  localparam logic PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [15:0]          gap_q, gap_d;
  logic [23:0]          tmo_q, tmo_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 send_q, send_d;
  logic [7:0]           rega_q, rega_d;
  logic [7:0]           value_q, value_d;

  logic [PTR_W-1:0]     win_s;
  logic                 win_vld_s;
  logic [PTR_W:0]       sum_s;
  logic [PTR_W-1:0]     idx_s;
  logic [PTR_W-1:0]     next_ptr_s;

  // Winner search: first pending requester at or above the pointer, with wrap.
  always_comb begin
    win_s     = '0;
    win_vld_s = 1'b0;
    sum_s     = '0;
    idx_s     = '0;
    if (PRIO0 && req[0]) begin
      win_vld_s = 1'b1;
    end else begin
      win_vld_s = 1'b0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum_s >= (PTR_W+1)'(NUM_REQ)) begin
        sum_s = sum_s - (PTR_W+1)'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PTR_W-1:0];
      if (!win_vld_s && req[idx_s] && (!PRIO0 || idx_s != '0)) begin
        win_vld_s = 1'b1;
        win_s     = idx_s;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // Pointer after completion; in priority mode serving requester 0 leaves the rotation untouched.
  always_comb begin
    if (PRIO0 && owner_q == '0) begin
      next_ptr_s = ptr_q;
    end else if (owner_q == PTR_W'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_q + 1'b1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    ack_d   = '0;
    err_d   = '0;
    grant_d = grant_q;
    send_d  = send_q;
    rega_d  = rega_q;
    value_d = value_q;
    case (state_q)
      S_IDLE: begin
        gap_d = 16'd0;
        tmo_d = 24'd0;
        if (win_vld_s) begin
          state_d          = S_ISSUE;
          owner_d          = win_s;
          grant_d          = '0;
          grant_d[win_s]   = 1'b1;
          send_d           = 1'b1;
          {rega_d, value_d} = cmd[{win_s, 4'd0} +: 16];
        end else begin
          grant_d = '0;
          send_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        // taken has precedence over a simultaneous timeout expiry
        if (sccb_taken) begin
          send_d         = 1'b0;
          ack_d[owner_q] = 1'b1;
          ptr_d          = next_ptr_s;
          gap_d          = GAP_CYCLES;
          state_d        = S_GAP;
        end else if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
          send_d         = 1'b0;
          err_d[owner_q] = 1'b1;
          ptr_d          = next_ptr_s;
          gap_d          = GAP_CYCLES;
          state_d        = S_GAP;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      S_GAP: begin
        if (gap_q == 16'd0) begin
          state_d = S_IDLE;
          grant_d = '0;
          tmo_d   = 24'd0;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        send_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gap_q   <= 16'd0;
      tmo_q   <= 24'd0;
      ack_q   <= '0;
      err_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      send_q  <= 1'b0;
      rega_q  <= 8'd0;
      value_q <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      send_q  <= send_d;
      rega_q  <= rega_d;
      value_q <= value_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign sccb_send  = send_q;
  assign sccb_rega  = rega_q;
  assign sccb_value = value_q;

endmodule
